// File: rtl/exec_pkg.sv
// Shared types and instruction field positions for the multi-cycle execute unit.
package exec_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_LD   = 4'h2,
    OP_ST   = 4'h3,
    OP_ADD  = 4'h4,
    OP_SUB  = 4'h5,
    OP_JMP  = 4'h6,
    OP_JZ   = 4'h7,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    FETCH_HI,
    FETCH_LO,
    EXEC,
    MEM,
    HALT
  } state_t;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RA_MSB  = 7;
  localparam int RA_LSB  = 4;
  localparam int RB_MSB  = 3;
  localparam int RB_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // Opcodes 8..E are undefined: they execute as NOP but raise the sticky illegal flag.
  function automatic logic op_defined(input logic [3:0] op);
    return !(op inside {[4'h8:4'hE]});
  endfunction

endpackage

// File: rtl/exec_regfile.sv
// Register file: two async read ports, one sync write port, sync reset to zero.
// Indices at or above NUM_REGS read as zero and ignore writes.
module exec_regfile #(
  parameter int DATA_BITS = 8,
  parameter int NUM_REGS  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           ra_addr,
  output logic [DATA_BITS-1:0] ra_data,
  input  logic [3:0]           rb_addr,
  output logic [DATA_BITS-1:0] rb_data,
  input  logic                 we,
  input  logic [3:0]           waddr,
  input  logic [DATA_BITS-1:0] wdata
);

  logic [DATA_BITS-1:0] regs [NUM_REGS];

  function automatic logic in_range(input logic [3:0] idx);
    return int'(idx) < NUM_REGS;
  endfunction

  assign ra_data = in_range(ra_addr) ? regs[ra_addr] : '0;
  assign rb_data = in_range(rb_addr) ? regs[rb_addr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && in_range(waddr)) begin
      regs[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/exec_unit_mc.sv
// Multi-cycle core: fetches 16-bit instructions as two bytes, executes, halts on HALT.
// 3 cycles per instruction (4 for LD/ST) at zero wait; every memory state stalls until mem_ready.
module exec_unit_mc
  import exec_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 8,
  parameter int NUM_REGS  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic                 mem_ready,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic [ADDR_BITS-1:0] pc,
  output logic                 carry,
  output logic                 halted,
  output logic                 illegal
);

  state_t               state, state_nxt;
  logic [15:0]          ir;
  opcode_t              op;
  logic [3:0]           rd_idx, ra_idx, rb_idx, rf_raddr_a, rf_waddr;
  logic [7:0]           imm;
  logic [DATA_BITS-1:0] imm_ext, rd_a, rd_b, rf_wdata;
  logic [ADDR_BITS-1:0] addr_ext, jmp_target, pc_seq, pc_nxt;
  logic [DATA_BITS:0]   add_res, sub_res;
  logic                 rf_we, jz_taken;

  assign op     = opcode_t'(ir[OP_MSB:OP_LSB]);
  assign rd_idx = ir[RD_MSB:RD_LSB];
  assign ra_idx = ir[RA_MSB:RA_LSB];
  assign rb_idx = ir[RB_MSB:RB_LSB];
  assign imm    = ir[IMM_MSB:IMM_LSB];

  assign imm_ext    = DATA_BITS'(imm);
  assign addr_ext   = ADDR_BITS'(imm);
  assign jmp_target = ADDR_BITS'({imm[7:1], 1'b0});
  assign pc_seq     = pc + ADDR_BITS'(2);

  // ST and JZ consume rd as a source, so port A is steered to it for those ops.
  assign rf_raddr_a = (op == OP_ST || op == OP_JZ) ? rd_idx : ra_idx;

  exec_regfile #(
    .DATA_BITS(DATA_BITS),
    .NUM_REGS (NUM_REGS)
  ) u_rf (
    .clk    (clk),
    .reset  (reset),
    .ra_addr(rf_raddr_a),
    .ra_data(rd_a),
    .rb_addr(rb_idx),
    .rb_data(rd_b),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata)
  );

  assign add_res  = {1'b0, rd_a} + {1'b0, rd_b};
  assign sub_res  = {1'b0, rd_a} - {1'b0, rd_b};
  assign jz_taken = (rd_a == '0);

  always_comb begin
    pc_nxt = pc_seq;
    case (op)
      OP_JMP:  pc_nxt = jmp_target;
      OP_JZ:   if (jz_taken) pc_nxt = jmp_target;
      OP_HALT: pc_nxt = pc;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH_HI;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH_HI: if (mem_ready) state_nxt = FETCH_LO;
      FETCH_LO: if (mem_ready) state_nxt = EXEC;
      EXEC: begin
        case (op)
          OP_LD, OP_ST: state_nxt = MEM;
          OP_HALT:      state_nxt = HALT;
          default:      state_nxt = FETCH_HI;
        endcase
      end
      MEM:      if (mem_ready) state_nxt = FETCH_HI;
      HALT:     state_nxt = HALT;
      default:  state_nxt = FETCH_HI;
    endcase
  end

  // Request outputs are gated by reset so an in-flight transfer is abandoned at once.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rf_we     = 1'b0;
    rf_waddr  = rd_idx;
    rf_wdata  = '0;
    halted    = (state == HALT);
    if (!reset) begin
      case (state)
        FETCH_HI: begin
          mem_req  = 1'b1;
          mem_addr = pc;
        end
        FETCH_LO: begin
          mem_req  = 1'b1;
          mem_addr = {pc[ADDR_BITS-1:1], 1'b1};
        end
        EXEC: begin
          case (op)
            OP_LDI: begin
              rf_we    = 1'b1;
              rf_wdata = imm_ext;
            end
            OP_ADD: begin
              rf_we    = 1'b1;
              rf_wdata = add_res[DATA_BITS-1:0];
            end
            OP_SUB: begin
              rf_we    = 1'b1;
              rf_wdata = sub_res[DATA_BITS-1:0];
            end
            default: ;
          endcase
        end
        MEM: begin
          mem_req  = 1'b1;
          mem_addr = addr_ext;
          if (op == OP_ST) begin
            mem_we    = 1'b1;
            mem_wdata = rd_a;
          end else begin
            rf_we    = mem_ready;
            rf_wdata = mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= '0;
      ir      <= '0;
      carry   <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        FETCH_HI: if (mem_ready) ir[15:8] <= mem_rdata[7:0];
        FETCH_LO: if (mem_ready) ir[7:0]  <= mem_rdata[7:0];
        EXEC: begin
          pc <= pc_nxt;
          if (op == OP_ADD) begin
            carry <= add_res[DATA_BITS];
          end else if (op == OP_SUB) begin
            carry <= sub_res[DATA_BITS];
          end
          if (!op_defined(ir[OP_MSB:OP_LSB])) begin
            illegal <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
